// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// pipeline_hazard_ctrl : load-use / redirect / freeze hazard control for the
// five-stage pipeline. Optional counters built when HAZ_PERF_CNT_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl #(
  parameter int REDIRECT_LAT = 2,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic             exmem_redirect,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             pc_redirect,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_REFETCH = 1'b1;
  localparam logic [3:0] LAT_INIT   = 4'(REDIRECT_LAT);

  logic [0:0] state_q, state_d;
  logic [3:0] lat_cnt_q, lat_cnt_d;
  logic       load_use;

  // $0 is hardwired zero, so a load targeting it never produces a dependency.
  assign load_use = idex_memread && (idex_rt != 5'd0) &&
                    ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= ST_RUN;
      lat_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    if (!dmem_busy) begin
      case (state_q)
        ST_RUN: begin
          if (exmem_redirect && (REDIRECT_LAT != 0)) begin
            state_d   = ST_REFETCH;
            lat_cnt_d = LAT_INIT;
          end
        end
        ST_REFETCH: begin
          if (lat_cnt_q <= 4'd1) begin
            state_d   = ST_RUN;
            lat_cnt_d = 4'd0;
          end else begin
            lat_cnt_d = lat_cnt_q - 4'd1;
          end
        end
        default: begin
          state_d   = ST_RUN;
          lat_cnt_d = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pc_redirect = 1'b0;
    if (!RST) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (dmem_busy) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
    end else if (state_q == ST_REFETCH) begin
      pc_write    = 1'b0;
      ifid_flush  = 1'b1;
    end else if (exmem_redirect) begin
      pc_redirect = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_flush  = 1'b1;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic             ev_stall, ev_flush, ev_freeze;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;

  assign ev_freeze = dmem_busy;
  assign ev_flush  = !dmem_busy && (state_q == ST_RUN) && exmem_redirect;
  assign ev_stall  = !dmem_busy && (state_q == ST_RUN) && !exmem_redirect && load_use;

  // Counters saturate rather than wrap so long runs stay monotonic.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    freeze_cnt_d = freeze_cnt_q;
    if (ev_stall && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (ev_flush && (flush_cnt_q != {CNT_W{1'b1}}))
      flush_cnt_d = flush_cnt_q + 1'b1;
    if (ev_freeze && (freeze_cnt_q != {CNT_W{1'b1}}))
      freeze_cnt_d = freeze_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign freeze_cnt = freeze_cnt_q;
`else
  assign stall_cnt  = '0;
  assign flush_cnt  = '0;
  assign freeze_cnt = '0;
`endif

endmodule

`default_nettype wire
